// File: rtl/pipe_adder_slice.sv
// One carry-chain slice of pipe_adder: a CHUNK-bit add with carry-in.
// Also reports the carry into its own MSB, which the top needs for signed overflow.
module pipe_adder_slice #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   logic [CHUNK:0] full;

   assign full   = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
   assign sum_o  = full[CHUNK-1:0];
   assign cout_o = full[CHUNK];
   // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out by XOR.
   assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES registered slices,
// with a valid/ready handshake per stage so that bubbles collapse under backpressure.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STG_SAFE = (STAGES < 1) ? 1 : STAGES;
   localparam int CHUNK    = WIDTH / STG_SAFE;

   if (STAGES < 1 || WIDTH < 2 || (WIDTH % STG_SAFE) != 0) begin : g_bad_params
      $error("pipe_adder: need WIDTH >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
   end

   logic [STAGES-1:0]            vld_q, vld_d, rdy, up_v, up_c, sl_co, sl_cm, cy_q, cy_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d, up_a, up_b, up_s;
   logic [STAGES-1:0][CHUNK-1:0] sl_s;
   logic                         cm_q, cm_d;
   logic                         r;
   logic                         unused_bits;

   // Ready ripples back from the output; an empty stage is always ready.
   always_comb begin
      r   = out_ready;
      rdy = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r      = !vld_q[k] || r;
         rdy[k] = r;
      end
   end

   always_comb begin
      up_v    = '0;
      up_c    = '0;
      up_a    = '0;
      up_b    = '0;
      up_s    = '0;
      up_v[0] = in_valid;
      up_c[0] = cin;
      up_a[0] = a;
      up_b[0] = b;
      for (int k = 1; k < STAGES; k++) begin
         up_v[k] = vld_q[k-1];
         up_c[k] = cy_q[k-1];
         up_a[k] = a_q[k-1];
         up_b[k] = b_q[k-1];
         up_s[k] = sum_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
         .a_i    (up_a[k][k*CHUNK +: CHUNK]),
         .b_i    (up_b[k][k*CHUNK +: CHUNK]),
         .cin_i  (up_c[k]),
         .sum_o  (sl_s[k]),
         .cout_o (sl_co[k]),
         .cmsb_o (sl_cm[k])
      );
   end

   always_comb begin
      vld_d = vld_q;
      cy_d  = cy_q;
      sum_d = sum_q;
      a_d   = a_q;
      b_d   = b_q;
      cm_d  = cm_q;
      for (int k = 0; k < STAGES; k++) begin
         if (rdy[k]) begin
            vld_d[k]                   = up_v[k];
            cy_d[k]                    = sl_co[k];
            a_d[k]                     = up_a[k];
            b_d[k]                     = up_b[k];
            sum_d[k]                   = up_s[k];
            sum_d[k][k*CHUNK +: CHUNK] = sl_s[k];
         end
      end
      if (rdy[STAGES-1]) cm_d = sl_cm[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         cy_q  <= '0;
         sum_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cm_q  <= 1'b0;
      end else begin
         vld_q <= vld_d;
         cy_q  <= cy_d;
         sum_q <= sum_d;
         a_q   <= a_d;
         b_q   <= b_d;
         cm_q  <= cm_d;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];
   assign ovf       = cy_q[STAGES-1] ^ cm_q;

   // Already-consumed operand chunks and inner MSB carries are carried but never read.
   assign unused_bits = ^{a_q, b_q, up_a, up_b, sl_cm};

endmodule
